// File: rtl/ibex_wb_arbiter_pkg.sv
// ibex_wb_arbiter_pkg
//   Definitions shared between the writeback arbiter and the register file:
//   the architectural register address width and the derivation of the
//   implemented address width / register count from the RV32E option.
//   Also holds the writeback source selector used inside the arbiter.

package ibex_wb_arbiter_pkg;

  // Width of every register address travelling through the pipeline.
  // RV32E only implements the lower half of the register space.
  localparam int unsigned RegAddrWidth = 5;

  // Number of address bits that index implemented registers.
  function automatic int unsigned addr_width(bit rv32e);
    return rv32e ? 4 : 5;
  endfunction

  // Number of implemented architectural registers.
  function automatic int unsigned num_regs(bit rv32e);
    return 1 << addr_width(rv32e);
  endfunction

  // Which source drives the register file write port in a given cycle.
  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_LSU  = 2'd1,
    WB_SRC_EX   = 2'd2
  } wb_src_e;

endpackage

// File: rtl/ibex_wb_load_fifo.sv
// ibex_wb_load_fifo
//   In-order FIFO of destination register addresses for loads that have been
//   issued but whose data has not yet come back from the LSU.
//
// Ports
//   clk_i        clock
//   rst_i        synchronous active-high reset; empties the FIFO
//   push_i       append push_addr_i at the tail (ignored when full)
//   push_addr_i  destination address of the newly issued load
//   pop_i        drop the head entry (ignored when empty)
//   full_o       Depth entries held
//   empty_o      no entries held
//   head_o       address of the oldest outstanding load

module ibex_wb_load_fifo
  import ibex_wb_arbiter_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_i,
  input  logic [RegAddrWidth-1:0] push_addr_i,
  input  logic                    pop_i,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [RegAddrWidth-1:0] head_o
);

  // A single-entry FIFO still needs a one-bit pointer to index the array.
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  logic [RegAddrWidth-1:0] mem_q [Depth];
  logic [PtrW-1:0]         wr_ptr_q;
  logic [PtrW-1:0]         rd_ptr_q;
  logic [CntW-1:0]         count_q;
  logic                    push_ok;
  logic                    pop_ok;

  // Pointers wrap at Depth, which need not be a power of two.
  function automatic logic [PtrW-1:0] next_ptr(logic [PtrW-1:0] ptr);
    return (ptr == LastPtr) ? '0 : ptr + PtrW'(1);
  endfunction

  assign full_o  = (count_q == FullCnt);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Overflow/underflow requests are dropped so the occupancy count can never
  // leave the 0..Depth range.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Storage: written at the tail on every accepted push. Contents need no
  // reset because the occupancy count alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_addr_i;
    end
  end

  // Pointer and occupancy bookkeeping. A simultaneous push and pop moves both
  // pointers and leaves the count unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= next_ptr(wr_ptr_q);
      end
      if (pop_ok) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ibex_wb_arbiter.sv
// ibex_wb_arbiter
//   Writeback stage in front of the register file's single write port.
//   Merges execute-stage results with load data returning from the LSU,
//   tracks outstanding loads (address FIFO + per-register pending bits) and
//   stalls execute only to avoid write-port conflicts and WAW reordering.
//
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   ex_valid_i        execute offers a result or a load issue
//   ex_ready_o        arbiter accepts (combinational, independent of valid)
//   ex_we_i           instruction writes a destination register
//   ex_load_i         instruction is a load; data arrives later from the LSU
//   ex_waddr_i        destination register (bit 4 ignored for RV32E)
//   ex_wdata_i        non-load result
//   lsu_rvalid_i      load response, in order, cannot be stalled
//   lsu_rdata_i       load data
//   lsu_err_i         load faulted; data invalid
//   rf_we_o           register file write enable (registered, one cycle)
//   rf_waddr_o        register file write address
//   rf_wdata_o        register file write data
//   pending_o         bit r set: a load to register r is outstanding
//   load_err_o        one-cycle pulse: faulted load retired
//   err_o             one-cycle pulse: response with no outstanding load

module ibex_wb_arbiter
  import ibex_wb_arbiter_pkg::*;
#(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned LoadDepth = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,

  input  logic                      ex_valid_i,
  output logic                      ex_ready_o,
  input  logic                      ex_we_i,
  input  logic                      ex_load_i,
  input  logic [RegAddrWidth-1:0]   ex_waddr_i,
  input  logic [DataWidth-1:0]      ex_wdata_i,

  input  logic                      lsu_rvalid_i,
  input  logic [DataWidth-1:0]      lsu_rdata_i,
  input  logic                      lsu_err_i,

  output logic                      rf_we_o,
  output logic [RegAddrWidth-1:0]   rf_waddr_o,
  output logic [DataWidth-1:0]      rf_wdata_o,

  output logic [num_regs(RV32E)-1:0] pending_o,
  output logic                      load_err_o,
  output logic                      err_o
);

  localparam int unsigned AddrWidth = addr_width(RV32E);
  localparam int unsigned NumRegs   = num_regs(RV32E);

  // Execute-side address with the unimplemented upper bit cleared for RV32E.
  logic [RegAddrWidth-1:0] ex_addr;
  logic [AddrWidth-1:0]    ex_idx;
  logic                    ex_addr_nz;
  logic                    ex_pending;

  logic                    fifo_full;
  logic                    fifo_empty;
  logic [RegAddrWidth-1:0] fifo_head;
  logic [AddrWidth-1:0]    head_idx;

  logic                    ex_accept;
  logic                    load_push;
  logic                    load_pop;

  logic [NumRegs-1:0]      pending_q;
  logic [NumRegs-1:0]      pending_d;
  wb_src_e                 wb_src;

  assign ex_addr    = RegAddrWidth'(ex_waddr_i[AddrWidth-1:0]);
  assign ex_idx     = ex_addr[AddrWidth-1:0];
  assign ex_addr_nz = |ex_addr;
  assign ex_pending = pending_q[ex_idx];
  assign head_idx   = fifo_head[AddrWidth-1:0];

  // Stall rules. A full FIFO blocks new loads even if a response frees an
  // entry this cycle, keeping the ready path off the LSU response timing.
  // A write to a register with a load in flight must wait, otherwise the
  // older load would land later and overwrite the newer result. A response
  // owns the write port outright since the LSU cannot be back-pressured.
  always_comb begin
    ex_ready_o = 1'b1;
    if (ex_load_i) begin
      if (fifo_full || (ex_addr_nz && ex_pending)) begin
        ex_ready_o = 1'b0;
      end
    end else if (ex_we_i) begin
      if ((ex_addr_nz && ex_pending) || lsu_rvalid_i) begin
        ex_ready_o = 1'b0;
      end
    end
  end

  assign ex_accept = ex_valid_i & ex_ready_o;
  assign load_push = ex_accept & ex_load_i;
  assign load_pop  = lsu_rvalid_i & ~fifo_empty;

  ibex_wb_load_fifo #(
    .Depth (LoadDepth)
  ) u_load_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (load_push),
    .push_addr_i (ex_addr),
    .pop_i       (load_pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

  // Pick the write-port source. The stall rules guarantee an accepted
  // execute write never coincides with a response, so the order only matters
  // for readability. Faulted loads and x0 destinations retire without a write.
  always_comb begin
    wb_src = WB_SRC_NONE;
    if (load_pop && !lsu_err_i && (fifo_head != '0)) begin
      wb_src = WB_SRC_LSU;
    end else if (ex_accept && !ex_load_i && ex_we_i && ex_addr_nz) begin
      wb_src = WB_SRC_EX;
    end
  end

  // Scoreboard update: the retiring load clears its bit, a newly accepted
  // load sets its bit. Both cannot hit the same register in one cycle
  // because a load to a pending register is stalled.
  always_comb begin
    pending_d = pending_q;
    if (load_pop) begin
      pending_d[head_idx] = 1'b0;
    end
    if (load_push && ex_addr_nz) begin
      pending_d[ex_idx] = 1'b1;
    end
  end

  // Registered write port, scoreboard and error pulses. The address and data
  // registers hold their last value when no write is issued.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
      pending_q  <= '0;
      load_err_o <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      rf_we_o    <= (wb_src != WB_SRC_NONE);
      pending_q  <= pending_d;
      load_err_o <= load_pop & lsu_err_i;
      err_o      <= lsu_rvalid_i & fifo_empty;
      case (wb_src)
        WB_SRC_LSU: begin
          rf_waddr_o <= fifo_head;
          rf_wdata_o <= lsu_rdata_i;
        end
        WB_SRC_EX: begin
          rf_waddr_o <= ex_addr;
          rf_wdata_o <= ex_wdata_i;
        end
        default: begin
          rf_waddr_o <= rf_waddr_o;
          rf_wdata_o <= rf_wdata_o;
        end
      endcase
    end
  end

  assign pending_o = pending_q;

endmodule

// File: tb/tb_ibex_wb_arbiter.sv
// tb_ibex_wb_arbiter
//   Self-checking bench for ibex_wb_arbiter (RV32E=0, LoadDepth=2).
//   The reference model keeps the outstanding loads as a plain queue of
//   destination addresses; pending bits and stall decisions are derived from
//   the queue contents each cycle.

module tb_ibex_wb_arbiter;

  localparam int unsigned LoadDepth = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic        ex_we_i;
  logic        ex_load_i;
  logic [4:0]  ex_waddr_i;
  logic [31:0] ex_wdata_i;
  logic        lsu_rvalid_i;
  logic [31:0] lsu_rdata_i;
  logic        lsu_err_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [31:0] pending_o;
  logic        load_err_o;
  logic        err_o;

  ibex_wb_arbiter #(
    .RV32E     (1'b0),
    .DataWidth (32),
    .LoadDepth (LoadDepth)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ex_valid_i   (ex_valid_i),
    .ex_ready_o   (ex_ready_o),
    .ex_we_i      (ex_we_i),
    .ex_load_i    (ex_load_i),
    .ex_waddr_i   (ex_waddr_i),
    .ex_wdata_i   (ex_wdata_i),
    .lsu_rvalid_i (lsu_rvalid_i),
    .lsu_rdata_i  (lsu_rdata_i),
    .lsu_err_i    (lsu_err_i),
    .rf_we_o      (rf_we_o),
    .rf_waddr_o   (rf_waddr_o),
    .rf_wdata_o   (rf_wdata_o),
    .pending_o    (pending_o),
    .load_err_o   (load_err_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference state: destinations of outstanding loads, oldest first.
  logic [4:0] model_q[$];

  // Expected registered outputs for the next sampling point.
  logic        exp_we;
  logic        exp_data_chk;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;
  logic        exp_load_err;
  logic        exp_err;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic bit in_flight(logic [4:0] a);
    foreach (model_q[i]) begin
      if (model_q[i] == a) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_pending();
    logic [31:0] p = '0;
    foreach (model_q[i]) begin
      if (model_q[i] != 5'd0) p[model_q[i]] = 1'b1;
    end
    return p;
  endfunction

  // One clock cycle: check last cycle's registered results, drive new
  // inputs, check the combinational ready, then advance the model.
  task automatic applyStimulus(input bit rst, input bit valid, input bit we, input bit load,
                               input logic [4:0] addr, input logic [31:0] wdata,
                               input bit rvalid, input logic [31:0] rdata, input bit lerr);
    bit ready;
    bit accept;
    logic [4:0] h;
    @(negedge clk_i);
    checkOutput("rf_we", 64'(rf_we_o), 64'(exp_we));
    if (exp_data_chk) begin
      checkOutput("rf_waddr", 64'(rf_waddr_o), 64'(exp_waddr));
      checkOutput("rf_wdata", 64'(rf_wdata_o), 64'(exp_wdata));
    end
    checkOutput("pending", 64'(pending_o), 64'(model_pending()));
    checkOutput("load_err", 64'(load_err_o), 64'(exp_load_err));
    checkOutput("err", 64'(err_o), 64'(exp_err));

    rst_i        = rst;
    ex_valid_i   = valid;
    ex_we_i      = we;
    ex_load_i    = load;
    ex_waddr_i   = addr;
    ex_wdata_i   = wdata;
    lsu_rvalid_i = rvalid;
    lsu_rdata_i  = rdata;
    lsu_err_i    = lerr;
    #1;

    if (load) begin
      ready = !((model_q.size() >= LoadDepth) || (addr != 0 && in_flight(addr)));
    end else if (we) begin
      ready = !((addr != 0 && in_flight(addr)) || rvalid);
    end else begin
      ready = 1'b1;
    end
    checkOutput("ex_ready", 64'(ex_ready_o), 64'(ready));

    exp_we = 0; exp_data_chk = 0; exp_load_err = 0; exp_err = 0;
    if (rst) begin
      model_q.delete();
      exp_data_chk = 1; exp_waddr = '0; exp_wdata = '0;
    end else begin
      accept = valid && ready;
      if (rvalid) begin
        if (model_q.size() > 0) begin
          h = model_q.pop_front();
          if (lerr) exp_load_err = 1;
          else if (h != 0) begin
            exp_we = 1; exp_data_chk = 1; exp_waddr = h; exp_wdata = rdata;
          end
        end else begin
          exp_err = 1;
        end
      end
      if (accept) begin
        if (load) model_q.push_back(addr);
        else if (we && addr != 0) begin
          exp_we = 1; exp_data_chk = 1; exp_waddr = addr; exp_wdata = wdata;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 5'd0, 32'd0, 0, 32'd0, 0);
  endtask

  // Shorthands for the directed scenarios.
  task automatic alu(input logic [4:0] a, input logic [31:0] d, input bit rv, input logic [31:0] rd);
    applyStimulus(0, 1, 1, 0, a, d, rv, rd, 0);
  endtask

  task automatic ld(input logic [4:0] a, input bit rv, input logic [31:0] rd, input bit le);
    applyStimulus(0, 1, 1, 1, a, 32'd0, rv, rd, le);
  endtask

  task automatic resp(input logic [31:0] rd, input bit le);
    applyStimulus(0, 0, 0, 0, 5'd0, 32'd0, 1, rd, le);
  endtask

  initial begin
    rst_i = 1; ex_valid_i = 0; ex_we_i = 0; ex_load_i = 0; ex_waddr_i = 0;
    ex_wdata_i = 0; lsu_rvalid_i = 0; lsu_rdata_i = 0; lsu_err_i = 0;
    repeat (2) @(posedge clk_i);
    exp_we = 0; exp_data_chk = 1; exp_waddr = 0; exp_wdata = 0;
    exp_load_err = 0; exp_err = 0;

    // Plain ALU write.
    alu(5'd5, 32'hDEAD_BEEF, 0, 0);
    idle(1);
    // Load to x7 answered three cycles later.
    ld(5'd7, 0, 0, 0);
    idle(2);
    resp(32'h0000_1234, 0);
    idle(1);
    // WAW stall: ALU to x7 waits for the outstanding load.
    ld(5'd7, 0, 0, 0);
    alu(5'd7, 32'hAAAA_5555, 0, 0);
    alu(5'd7, 32'hAAAA_5555, 0, 0);
    alu(5'd7, 32'hAAAA_5555, 1, 32'h0000_7777);
    alu(5'd7, 32'hAAAA_5555, 0, 0);
    idle(1);
    // Fill the FIFO, offer a third load, retire in order.
    ld(5'd3, 0, 0, 0);
    ld(5'd4, 0, 0, 0);
    ld(5'd6, 0, 0, 0);
    ld(5'd6, 1, 32'h3333_0003, 0);
    ld(5'd6, 0, 0, 0);
    // Port conflict: ALU x9 collides with responses.
    alu(5'd9, 32'h9999_0009, 1, 32'h4444_0004);
    alu(5'd9, 32'h9999_0009, 1, 32'h6666_0006);
    alu(5'd9, 32'h9999_0009, 0, 0);
    idle(1);
    // Faulted load, response with nothing outstanding.
    ld(5'd2, 0, 0, 0);
    resp(32'hBAD0_BAD0, 1);
    resp(32'h0BAD_0BAD, 0);
    idle(1);
    // Load to x0 retires without a write.
    ld(5'd0, 0, 0, 0);
    resp(32'h1111_1111, 0);
    // Reset with two loads outstanding; stale response afterwards.
    ld(5'd3, 0, 0, 0);
    ld(5'd4, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 5'd0, 32'd0, 0, 32'd0, 0);
    idle(1);
    resp(32'h5555_5555, 0);
    idle(1);

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 2000; n++) begin
      bit r_rst, r_valid, r_we, r_load, r_rv, r_le;
      r_rst   = ($urandom_range(0, 99) == 0);
      r_valid = ($urandom_range(0, 9) < 7);
      r_load  = ($urandom_range(0, 9) < 4);
      r_we    = ($urandom_range(0, 9) < 7);
      if (model_q.size() > 0) r_rv = ($urandom_range(0, 9) < 4);
      else                    r_rv = ($urandom_range(0, 19) == 0);
      r_le    = ($urandom_range(0, 6) == 0);
      applyStimulus(r_rst, r_valid, r_we, r_load, 5'($urandom_range(0, 7)),
                    $urandom, r_rv, $urandom, r_le);
    end
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
